// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader: framed byte stream -> 32-bit LE words.
// Holds the CPU in reset until a frame with a good checksum is written.
//
// Ports:
//   MAX10_CLK1_50 : clock, rising edge
//   reset         : async active-low reset
//   start         : pulse, begins a load from IDLE/DONE/ERROR
//   in_valid/in_data/in_ready : byte stream handshake
//   imem_wr_en/imem_addr/imem_wr_data : instruction memory write port
//   cpu_reset     : active-high CPU reset
//   load_done/load_error : result of the last load
//   words_written : words written by the current/last load
module imem_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit BOOT_HOLD   = 1'b1
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_written
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [7:0]          chk_q, chk_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     ww_q, ww_d;

    logic        active;
    logic        xfer;
    logic [15:0] n_full;
    logic [31:0] word_nxt;
    logic [16:0] ww_ext;

    assign active = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CHK);
    assign xfer     = in_valid & active;
    assign n_full   = {in_data, len_q[7:0]};
    // Bytes shift in from the top so the first byte ends up in [7:0].
    assign word_nxt = {in_data, word_q[31:8]};
    assign ww_ext   = 17'(ww_q);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        word_d    = word_q;
        bcnt_d    = bcnt_q;
        chk_d     = chk_q;
        timer_d   = timer_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        ww_d      = ww_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_LEN0;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    ww_d      = '0;
                    chk_d     = '0;
                    timer_d   = '0;
                    bcnt_d    = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    chk_d      = chk_q ^ in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    chk_d       = chk_q ^ in_data;
                    bcnt_d      = '0;
                    if ({1'b0, n_full} > MAX_WORDS) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (n_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    chk_d  = chk_q ^ in_data;
                    word_d = word_nxt;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wr_en_d = 1'b1;
                        addr_d  = ww_q[ADDR_W-1:0];
                        wdata_d = word_nxt;
                        ww_d    = ww_q + 1'b1;
                        if (ww_ext + 17'd1 == {1'b0, len_q})
                            state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog inside a frame.
        if (active) begin
            if (xfer) begin
                timer_d = '0;
            end else if (timer_q == TMO_LAST) begin
                state_d = S_ERROR;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            word_q    <= '0;
            bcnt_q    <= '0;
            chk_q     <= '0;
            timer_q   <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= BOOT_HOLD;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ww_q      <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            word_q    <= word_d;
            bcnt_q    <= bcnt_d;
            chk_q     <= chk_d;
            timer_q   <= timer_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ww_q      <= ww_d;
        end
    end

    assign in_ready      = active;
    assign imem_wr_en    = wr_en_q;
    assign imem_addr     = addr_q;
    assign imem_wr_data  = wdata_q;
    assign cpu_reset     = cpu_rst_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: scoreboarded memory writes,
// checksum, length bounds, timeout and reset behaviour.
module tb_imem_boot_loader;

    localparam int AW  = 8;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_written;

    imem_boot_loader #(
        .ADDR_W(AW),
        .TIMEOUT_CYC(TMO),
        .BOOT_HOLD(1'b1)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_wr_en(imem_wr_en),
        .imem_addr(imem_addr),
        .imem_wr_data(imem_wr_data),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .load_error(load_error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int extra = 0;
    int stalls = 0;
    int cyc = 0;
    int last_wr = -1;
    bit gap_en = 1'b0;
    logic [AW+31:0] sb[$];
    logic [31:0] fw[8];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && imem_wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                extra++;
            end else begin
                check("wr_word", {imem_addr, imem_wr_data}, sb.pop_front());
            end
            if (gap_en && last_wr >= 0)
                check("wr_gap", cyc - last_wr, 4);
            last_wr = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic st);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        k = 0;
        if (!in_ready) stalls++;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("in_ready", in_ready, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("st_done", load_done, 0);
        check("st_err", load_error, 0);
        check("st_ww", words_written, 0);
        check("st_cpurst", cpu_reset, 1);
        check("st_rdy", in_ready, 1);
    endtask

    task automatic send_frame(input int n, input logic bad, input logic ms);
        logic [7:0] c;
        logic [7:0] b;
        logic [15:0] nn;
        nn = 16'(n);
        c = 8'h00;
        last_wr = -1;
        send_byte(nn[7:0], ms);
        c = c ^ nn[7:0];
        send_byte(nn[15:8], 1'b0);
        c = c ^ nn[15:8];
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = fw[i][8*j +: 8];
                if (j == 3) sb.push_back({AW'(i), fw[i]});
                send_byte(b, ms && (j == 1));
                c = c ^ b;
            end
        end
        send_byte(bad ? (c ^ 8'h01) : c, 1'b0);
        check("cpurst_pre", cpu_reset, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_rdy", in_ready, 0);
        check("rst_wr", imem_wr_en, 0);
        check("rst_cpurst", cpu_reset, 1);
        check("rst_done", load_done, 0);
        check("rst_ww", words_written, 0);
        rst_n = 1'b1;

        // Two-word frame, good checksum 0x39.
        start_load();
        fw[0] = 32'h2000_0013;
        fw[1] = 32'h0000_0008;
        send_frame(2, 1'b0, 1'b0);
        idle();
        check("t2_cpurst", cpu_reset, 0);
        check("t2_done", load_done, 1);
        check("t2_err", load_error, 0);
        check("t2_ww", words_written, 2);
        check("t2_wrcnt", wr_cnt, 2);

        // Same frame, bad checksum 0x38.
        start_load();
        send_frame(2, 1'b1, 1'b0);
        idle();
        check("t3_err", load_error, 1);
        check("t3_done", load_done, 0);
        check("t3_cpurst", cpu_reset, 1);
        check("t3_ww", words_written, 2);
        check("t3_wrcnt", wr_cnt, 4);

        // Reset in the middle of a word.
        start_load();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        in_data = 8'h20;
        rst_n = 1'b0;
        #1;
        check("t1_rdy", in_ready, 0);
        check("t1_wr", imem_wr_en, 0);
        check("t1_addr", imem_addr, 0);
        check("t1_data", imem_wr_data, 0);
        check("t1_cpurst", cpu_reset, 1);
        check("t1_ww", words_written, 0);
        repeat (3) @(negedge clk);
        check("t1_wrcnt", wr_cnt, 4);
        check("t1_rdy2", in_ready, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // N = 257 exceeds 2**ADDR_W.
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        idle();
        check("t4_err", load_error, 1);
        check("t4_rdy", in_ready, 0);
        check("t4_ww", words_written, 0);
        check("t4_wrcnt", wr_cnt, 4);

        // Empty frame.
        start_load();
        send_frame(0, 1'b0, 1'b0);
        idle();
        check("t5_done", load_done, 1);
        check("t5_cpurst", cpu_reset, 0);
        check("t5_ww", words_written, 0);
        check("t5_wrcnt", wr_cnt, 4);

        // Timeout after a single data byte.
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        idle();
        repeat (TMO - 1) @(negedge clk);
        check("t5_tmo_pre", load_error, 0);
        @(negedge clk);
        check("t5_tmo_err", load_error, 1);
        check("t5_tmo_rdy", in_ready, 0);
        check("t5_tmo_cpurst", cpu_reset, 1);

        // Back-to-back 4-word frame with ignored mid-frame starts.
        start_load();
        fw[0] = 32'hDEAD_BEEF;
        fw[1] = 32'h0123_4567;
        fw[2] = 32'h89AB_CDEF;
        fw[3] = 32'h0000_0073;
        stalls = 0;
        gap_en = 1'b1;
        send_frame(4, 1'b0, 1'b1);
        idle();
        gap_en = 1'b0;
        check("t6_done", load_done, 1);
        check("t6_cpurst", cpu_reset, 0);
        check("t6_ww", words_written, 4);
        check("t6_stalls", stalls, 0);
        @(negedge clk);
        check("t6_wrcnt", wr_cnt, 8);
        check("sb_left", sb.size(), 0);
        check("wr_extra", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
